// File: rtl/bit_destuffer.sv
// Receive-side bit destuffer: removes the stuff bit after five equal bits
// inside the stuffing window and flags a sixth equal bit as a stuff error.
module bit_destuffer (
  input  logic       clk,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX_IN,
  input  logic       STF_EN,
  output logic       RX,
  output logic       SP_OUT,
  output logic       F_STF,
  output logic [7:0] STF_CNT
);

  typedef enum logic [1:0] {IDLE, RUN, DESTUFF, ERR} state_t;

  state_t      state_q;
  logic [2:0]  run_q;
  logic        last_q;
  logic [3:0]  rec_q;
  logic        rx_q;
  logic        sp_out_q;
  logic        f_stf_q;
  logic [7:0]  cnt_q;

  logic [2:0]  run_d;
  logic [7:0]  cnt_d;
  logic [3:0]  rec_d;

  assign run_d = run_q + 3'd1;
  assign cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign rec_d = rec_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      run_q    <= 3'd0;
      last_q   <= 1'b1;
      rec_q    <= 4'd0;
      rx_q     <= 1'b1;
      sp_out_q <= 1'b0;
      f_stf_q  <= 1'b1;
      cnt_q    <= 8'd0;
    end else begin
      sp_out_q <= 1'b0;
      if (SP) begin
        case (state_q)
          IDLE: begin
            rx_q     <= RX_IN;
            sp_out_q <= 1'b1;
            if (!RX_IN) begin
              state_q <= RUN;
              last_q  <= 1'b0;
              run_q   <= 3'd1;
              cnt_q   <= 8'd0;
            end
          end
          RUN: begin
            rx_q     <= RX_IN;
            sp_out_q <= 1'b1;
            // Closed window: the bit is delivered but no longer counted.
            if (!STF_EN) begin
              state_q <= IDLE;
            end else if (RX_IN == last_q) begin
              run_q <= run_d;
              if (run_d == 3'd5) state_q <= DESTUFF;
            end else begin
              run_q  <= 3'd1;
              last_q <= RX_IN;
            end
          end
          DESTUFF: begin
            if (RX_IN != last_q) begin
              last_q  <= RX_IN;
              run_q   <= 3'd1;
              cnt_q   <= cnt_d;
              state_q <= STF_EN ? RUN : IDLE;
            end else begin
              f_stf_q <= 1'b0;
              rec_q   <= 4'd0;
              state_q <= ERR;
            end
          end
          ERR: begin
            // Leave only after 11 consecutive recessive samples.
            if (RX_IN) begin
              if (rec_q == 4'd10) begin
                f_stf_q <= 1'b1;
                rec_q   <= 4'd0;
                state_q <= IDLE;
              end else begin
                rec_q <= rec_d;
              end
            end else begin
              rec_q <= 4'd0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign RX      = rx_q;
  assign SP_OUT  = sp_out_q;
  assign F_STF   = f_stf_q;
  assign STF_CNT = cnt_q;

endmodule

// File: tb/tb_bit_destuffer.sv
// Bench for bit_destuffer: directed frames plus random traffic against a
// history-based reference model.
module tb_bit_destuffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       SP;
  logic       RX_IN;
  logic       STF_EN;
  logic       RX;
  logic       SP_OUT;
  logic       F_STF;
  logic [7:0] STF_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  bit in_frame, want_stuff, in_err;
  bit hist[$];              // current run of equal bits within the frame
  int rec;
  int m_cnt;
  bit m_rx, m_f;

  bit_destuffer dut (
    .clk(clk), .reset(reset), .SP(SP), .RX_IN(RX_IN), .STF_EN(STF_EN),
    .RX(RX), .SP_OUT(SP_OUT), .F_STF(F_STF), .STF_CNT(STF_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    in_frame = 0; want_stuff = 0; in_err = 0;
    hist.delete();
    rec = 0; m_cnt = 0; m_rx = 1; m_f = 1;
  endtask

  task automatic send(input bit x, input bit en);
    bit e_sp;
    e_sp = 0;
    if (in_err) begin
      rec = x ? rec + 1 : 0;
      if (rec == 11) begin in_err = 0; m_f = 1; rec = 0; end
    end else if (want_stuff) begin
      want_stuff = 0;
      if (x != hist[$]) begin
        hist.delete(); hist.push_back(x);
        if (m_cnt < 255) m_cnt++;
        in_frame = en;
      end else begin
        in_frame = 0; in_err = 1; m_f = 0; rec = 0;
      end
    end else begin
      e_sp = 1; m_rx = x;
      if (!in_frame) begin
        if (!x) begin in_frame = 1; hist.delete(); hist.push_back(x); m_cnt = 0; end
      end else if (!en) begin
        in_frame = 0;
      end else begin
        if (x != hist[$]) hist.delete();
        hist.push_back(x);
        if (hist.size() >= 5) want_stuff = 1;
      end
    end
    @(negedge clk);
    SP = 1; RX_IN = x; STF_EN = en;
    @(negedge clk);
    SP = 0;
    chk("sp_out", SP_OUT, e_sp);
    if (e_sp) chk("rx", RX, m_rx);
    chk("f_stf", F_STF, m_f);
    chk("stf_cnt", STF_CNT, m_cnt[7:0]);
    repeat ($urandom_range(1, 2)) begin
      @(negedge clk);
      chk("sp_out_gap", SP_OUT, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_rx", RX, 1'b1);
    chk("rst_sp_out", SP_OUT, 1'b0);
    chk("rst_f_stf", F_STF, 1'b1);
    chk("rst_cnt", STF_CNT, 8'd0);
    // strobes while held in reset must be ignored
    @(negedge clk); SP = 1; RX_IN = 0; STF_EN = 1;
    @(negedge clk); SP = 0;
    chk("rst_sp_ignored", SP_OUT, 1'b0);
    chk("rst_cnt_hold", STF_CNT, 8'd0);
    reset = 1;
    mdl_reset();
    @(negedge clk);
  endtask

  task automatic eof();
    repeat (7) send(1'b1, 1'b0);
  endtask

  initial begin
    bit b;
    reset = 0; SP = 0; RX_IN = 1; STF_EN = 0;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("init_rx", RX, 1'b1);
    chk("init_sp_out", SP_OUT, 1'b0);
    chk("init_f_stf", F_STF, 1'b1);
    chk("init_cnt", STF_CNT, 8'd0);
    reset = 1;
    @(negedge clk);

    // dominant run with stuff bit
    repeat (5) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    chk("dom_stuff_cnt", STF_CNT, 8'd1);
    chk("dom_stuff_f", F_STF, 1'b1);
    eof();
    chk("eof_cnt_kept", STF_CNT, 8'd1);
    chk("eof_rx", RX, 1'b1);

    // recessive run with stuff bit
    send(1'b0, 1'b1);
    repeat (5) send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    chk("rec_stuff_cnt", STF_CNT, 8'd1);
    eof();

    // stuff error and recovery
    repeat (6) send(1'b0, 1'b1);
    chk("err_flag", F_STF, 1'b0);
    repeat (10) send(1'b1, 1'b1);
    chk("err_hold", F_STF, 1'b0);
    send(1'b1, 1'b1);
    chk("err_clear", F_STF, 1'b1);
    send(1'b1, 1'b1);
    chk("err_idle_pass", SP_OUT, 1'b0);

    // reset while waiting for a stuff bit
    repeat (5) send(1'b0, 1'b1);
    do_reset();
    send(1'b0, 1'b1);
    chk("post_rst_cnt", STF_CNT, 8'd0);
    eof();

    // counter saturation
    b = 0;
    send(1'b0, 1'b1);
    repeat (260) begin
      repeat (4) send(b, 1'b1);
      send(~b, 1'b1);
      b = ~b;
    end
    chk("sat_cnt", STF_CNT, 8'd255);
    eof();
    chk("sat_cnt_eof", STF_CNT, 8'd255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit x, en;
      if (in_err)                          x = ($urandom_range(0, 9) != 0);
      else if ($urandom_range(0, 9) < 7)   x = m_rx;
      else                                 x = $urandom_range(0, 1);
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      send(x, en);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
